voice_slot_sequencer: RTL and testbench

Time-division sequencer for the shared accumulator datapath of the sound generator. It divides CK into voice slots of four phases, drives the per-phase strobes for parameter read, accumulator clear/load and write-back, and arbitrates the single parameter-RAM port between voice reads and CPU writes. It sits between the CPU bus interface and the adder/latch datapath and emits one FRAME pulse per output sample.

---
 rtl/voice_slot_sequencer.sv | 156 +++++++++++++++
 tb/tb_voice_slot_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_slot_sequencer.sv
// Time-division voice slot sequencer: four-phase slot counter, datapath strobes and
// parameter-RAM port arbitration. Optional trailing idle slot enabled by SEQ_IDLE_SLOT_EN.
module voice_slot_sequencer #(
   parameter int unsigned VOICES = 16,
   parameter int unsigned VW     = 4,
   parameter int unsigned DW     = 8
) (
   input  logic          CK,
   input  logic          CL,
   input  logic          RUN,
   output logic [VW-1:0] VOICE,
   output logic [1:0]    PHASE,
   output logic [3:0]    PH_STB,
   output logic          PRD_EN,
   output logic [VW-1:0] PRD_ADDR,
   output logic          ACC_CLR,
   output logic          ACC_LD,
   output logic          WB_EN,
   output logic          FRAME,
   output logic          BUSY,
   input  logic          WREQ,
   input  logic [VW-1:0] WADDR,
   input  logic [DW-1:0] WDATA,
   output logic          WACK,
   output logic          PWR_EN,
   output logic [VW-1:0] PWR_ADDR,
   output logic [DW-1:0] PWR_DATA
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [VW-1:0] LastVoice = VW'(VOICES - 1);

   state_e          state_q, state_d;
   logic [VW+1:0]   cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic            rearm_q, rearm_d;
   logic            wack_q;
   logic [VW-1:0]   waddr_q;
   logic [DW-1:0]   wdata_q;
   logic            active, last, frame_end, islot, grant, capture;

   assign VOICE    = cnt_q[VW+1:2];
   assign PHASE    = cnt_q[1:0];
   assign active   = (state_q != StIdle);
   assign last     = (VOICE == LastVoice) && (PHASE == 2'd3);

`ifdef SEQ_IDLE_SLOT_EN
   logic islot_q, islot_d;
   assign islot     = islot_q;
   assign frame_end = islot_q && (PHASE == 2'd3);
`else
   assign islot     = 1'b0;
   assign frame_end = last;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + (VW+2)'(1);
`ifdef SEQ_IDLE_SLOT_EN
      // Idle slot holds voice 0 while the phase bits count; it ends the frame.
      islot_d = islot_q;
      if (islot_q) begin
         if (PHASE == 2'd3) begin
            islot_d = 1'b0;
            cnt_d   = '0;
         end
      end else if (last) begin
         islot_d = 1'b1;
         cnt_d   = '0;
      end
`endif
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (RUN) state_d = StRun;
         end
         StRun: begin
            if (!RUN) state_d = StDrain;
         end
         StDrain: begin
            if (RUN) begin
               state_d = StRun;
            end else if (frame_end) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Capture and grant are mutually exclusive because they key off opposite pend_q values.
   assign grant   = pend_q && (!active || (PHASE == 2'd2) || islot);
   assign capture = !pend_q && rearm_q && WREQ;

   always_comb begin
      pend_d  = pend_q;
      rearm_d = rearm_q;
      if (capture) begin
         pend_d  = 1'b1;
         rearm_d = 1'b0;
      end else begin
         if (grant) pend_d = 1'b0;
         if (!WREQ) rearm_d = 1'b1;
      end
   end

   always_ff @(posedge CK) begin
      if (CL) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         rearm_q <= 1'b1;
         wack_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
`ifdef SEQ_IDLE_SLOT_EN
         islot_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         rearm_q <= rearm_d;
         wack_q  <= grant;
         if (capture) begin
            waddr_q <= WADDR;
            wdata_q <= WDATA;
         end
`ifdef SEQ_IDLE_SLOT_EN
         islot_q <= islot_d;
`endif
      end
   end

   always_comb begin
      PH_STB  = active ? ~(4'b0001 << PHASE) : 4'b1111;
      PRD_EN  = active && !islot && (PHASE == 2'd0);
      ACC_CLR = active && !islot && (PHASE == 2'd0);
      ACC_LD  = active && !islot && (PHASE == 2'd1);
      WB_EN   = active && !islot && (PHASE == 2'd3);
      FRAME   = active && frame_end;
      BUSY    = active;
   end

   assign PRD_ADDR = VOICE;
   assign PWR_EN   = grant;
   assign PWR_ADDR = waddr_q;
   assign PWR_DATA = wdata_q;
   assign WACK     = wack_q;

endmodule

// File: tb/tb_voice_slot_sequencer.sv
// Self-checking bench for voice_slot_sequencer: frame-position model compared every cycle,
// plus directed scenarios with literal expectations. Honours SEQ_IDLE_SLOT_EN.
module tb_voice_slot_sequencer;

   localparam int VOICES = 16;
   localparam int VW     = 4;
   localparam int DW     = 8;
`ifdef SEQ_IDLE_SLOT_EN
   localparam int FL = 4 * (VOICES + 1);
`else
   localparam int FL = 4 * VOICES;
`endif

   logic          CK = 1'b0;
   logic          CL = 1'b1;
   logic          RUN = 1'b0;
   logic [VW-1:0] VOICE;
   logic [1:0]    PHASE;
   logic [3:0]    PH_STB;
   logic          PRD_EN;
   logic [VW-1:0] PRD_ADDR;
   logic          ACC_CLR, ACC_LD, WB_EN, FRAME, BUSY;
   logic          WREQ = 1'b0;
   logic [VW-1:0] WADDR = '0;
   logic [DW-1:0] WDATA = '0;
   logic          WACK, PWR_EN;
   logic [VW-1:0] PWR_ADDR;
   logic [DW-1:0] PWR_DATA;

   voice_slot_sequencer #(.VOICES(VOICES), .VW(VW), .DW(DW)) dut (
      .CK(CK), .CL(CL), .RUN(RUN), .VOICE(VOICE), .PHASE(PHASE), .PH_STB(PH_STB),
      .PRD_EN(PRD_EN), .PRD_ADDR(PRD_ADDR), .ACC_CLR(ACC_CLR), .ACC_LD(ACC_LD),
      .WB_EN(WB_EN), .FRAME(FRAME), .BUSY(BUSY), .WREQ(WREQ), .WADDR(WADDR),
      .WDATA(WDATA), .WACK(WACK), .PWR_EN(PWR_EN), .PWR_ADDR(PWR_ADDR),
      .PWR_DATA(PWR_DATA)
   );

   always #5 CK = ~CK;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: mode 0 idle, 1 run, 2 drain; pos is the cycle index within the frame.
   int   m_mode = 0, m_pos = 0;
   bit   m_pend = 0, m_armed = 1, m_wack = 0, m_valid = 0;
   int   m_addr = 0, m_data = 0;

   function automatic bit m_grant();
      return m_pend && (m_mode == 0 || (m_pos % 4) == 2 || m_pos >= 4 * VOICES);
   endfunction

   always @(posedge CK) begin : model
      int  pos_n, mode_n;
      bit  g, cap;
      if (CL) begin
         m_mode <= 0; m_pos <= 0; m_pend <= 0; m_armed <= 1; m_wack <= 0;
         m_addr <= 0; m_data <= 0; m_valid <= 1;
      end else begin
         g      = m_grant();
         cap    = !m_pend && m_armed && WREQ;
         mode_n = m_mode;
         pos_n  = (m_pos + 1) % FL;
         if (m_mode == 0) begin
            pos_n = 0;
            if (RUN) mode_n = 1;
         end else if (m_mode == 1) begin
            if (!RUN) mode_n = 2;
         end else begin
            if (RUN) mode_n = 1;
            else if (m_pos == FL - 1) begin mode_n = 0; pos_n = 0; end
         end
         m_mode <= mode_n;
         m_pos  <= pos_n;
         m_wack <= g;
         if (cap) begin
            m_pend <= 1; m_armed <= 0; m_addr <= int'(WADDR); m_data <= int'(WDATA);
         end else begin
            if (g) m_pend <= 0;
            if (!WREQ) m_armed <= 1;
         end
      end
   end

   int cyc = 0, pwr_cnt = 0, frame_last = -1, frame_prev = -1;

   always @(negedge CK) begin : compare
      int  ev, ep;
      bit  act, isl;
      cyc++;
      if (PWR_EN === 1'b1) pwr_cnt++;
      if (FRAME === 1'b1) begin frame_prev = frame_last; frame_last = cyc; end
      if (m_valid) begin
         act = (m_mode != 0);
         isl = (m_pos >= 4 * VOICES);
         ev  = isl ? 0 : m_pos / 4;
         ep  = m_pos % 4;
         chk("VOICE", 32'(VOICE), 32'(ev));
         chk("PHASE", 32'(PHASE), 32'(ep));
         chk("PRD_ADDR", 32'(PRD_ADDR), 32'(ev));
         chk("PH_STB", 32'(PH_STB), act ? 32'(4'hF & ~(4'b1 << ep)) : 32'hF);
         chk("PRD_EN", 32'(PRD_EN), 32'(act && !isl && ep == 0));
         chk("ACC_CLR", 32'(ACC_CLR), 32'(act && !isl && ep == 0));
         chk("ACC_LD", 32'(ACC_LD), 32'(act && !isl && ep == 1));
         chk("WB_EN", 32'(WB_EN), 32'(act && !isl && ep == 3));
         chk("FRAME", 32'(FRAME), 32'(act && m_pos == FL - 1));
         chk("BUSY", 32'(BUSY), 32'(act));
         chk("PWR_EN", 32'(PWR_EN), 32'(m_grant()));
         chk("PWR_ADDR", 32'(PWR_ADDR), 32'(m_addr));
         chk("PWR_DATA", 32'(PWR_DATA), 32'(m_data));
         chk("WACK", 32'(WACK), 32'(m_wack));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CK);
      #1;
   endtask

   int c0;

   initial begin
      // Reset
      tick(2);
      chk("rst BUSY", 32'(BUSY), 0);
      chk("rst PH_STB", 32'(PH_STB), 32'hF);
      chk("rst VOICE", 32'(VOICE), 0);
      chk("rst WACK", 32'(WACK), 0);
      chk("rst PWR_ADDR", 32'(PWR_ADDR), 0);
      CL = 0;
      tick(1);

      // Start: first slot one cycle after RUN, FRAME 64 cycles after RUN
      RUN = 1;
      tick(1);
      chk("start VOICE", 32'(VOICE), 0);
      chk("start PHASE", 32'(PHASE), 0);
      chk("start PH_STB", 32'(PH_STB), 32'hE);
      chk("start PRD_EN", 32'(PRD_EN), 1);
      tick(63);
      chk("t64 VOICE", 32'(VOICE), 15);
      chk("t64 PHASE", 32'(PHASE), 3);
`ifdef SEQ_IDLE_SLOT_EN
      chk("t64 FRAME", 32'(FRAME), 0);
`else
      chk("t64 FRAME", 32'(FRAME), 1);
`endif

      // Drop RUN at voice 5 phase 1, drain to end of frame
      tick(FL - 63 + 21);
      chk("drop VOICE", 32'(VOICE), 5);
      chk("drop PHASE", 32'(PHASE), 1);
      RUN = 0;
      tick(FL - 1 - 21);
      chk("drain FRAME", 32'(FRAME), 1);
      chk("drain BUSY", 32'(BUSY), 1);
      tick(1);
      chk("idle BUSY", 32'(BUSY), 0);
      chk("idle VOICE", 32'(VOICE), 0);
      chk("idle PH_STB", 32'(PH_STB), 32'hF);

      // CPU write captured at voice 2 phase 3, granted at voice 3 phase 2
      RUN = 1;
      tick(12);
      WREQ = 1; WADDR = 4'd3; WDATA = 8'hA5;
      tick(1);
      WREQ = 0;
      tick(2);
      chk("wr PWR_EN", 32'(PWR_EN), 1);
      chk("wr VOICE", 32'(VOICE), 3);
      chk("wr PHASE", 32'(PHASE), 2);
      chk("wr PWR_ADDR", 32'(PWR_ADDR), 3);
      chk("wr PWR_DATA", 32'(PWR_DATA), 32'hA5);
      tick(1);
      chk("wr WACK", 32'(WACK), 1);

      // Reset one cycle after capture discards the pending write
      tick(1);
      c0 = pwr_cnt;
      WREQ = 1; WADDR = 4'd9; WDATA = 8'h3C;
      tick(1);
      WREQ = 0; CL = 1; RUN = 0;
      tick(1);
      chk("clr PWR_EN", 32'(PWR_EN), 0);
      chk("clr WACK", 32'(WACK), 0);
      chk("clr BUSY", 32'(BUSY), 0);
      chk("clr PWR_DATA", 32'(PWR_DATA), 0);
      CL = 0;
      tick(4);
      chk("clr no write", 32'(pwr_cnt - c0), 0);

      // IDLE: WREQ held 20 cycles yields one write; re-raise yields a second
      c0 = pwr_cnt;
      WREQ = 1; WADDR = 4'd7; WDATA = 8'h5A;
      tick(1);
      chk("idle PWR_EN", 32'(PWR_EN), 1);
      chk("idle PWR_ADDR", 32'(PWR_ADDR), 7);
      tick(1);
      chk("idle WACK", 32'(WACK), 1);
      tick(18);
      WREQ = 0;
      tick(1);
      chk("held one write", 32'(pwr_cnt - c0), 1);
      WREQ = 1; WADDR = 4'd1; WDATA = 8'h11;
      tick(1);
      chk("rearm PWR_EN", 32'(PWR_EN), 1);
      chk("rearm PWR_DATA", 32'(PWR_DATA), 32'h11);
      WREQ = 0;
      tick(2);
      chk("two writes", 32'(pwr_cnt - c0), 2);

      // Continuous run: FRAME period
      RUN = 1;
      tick(3 * FL + 2);
      chk("frame period", 32'(frame_last - frame_prev), 32'(FL));
`ifdef SEQ_IDLE_SLOT_EN
      tick(62);
      WREQ = 1; WADDR = 4'd4; WDATA = 8'h77;
      tick(1);
      WREQ = 0;
      chk("islot PWR_EN", 32'(PWR_EN), 1);
      chk("islot VOICE", 32'(VOICE), 0);
      chk("islot PHASE", 32'(PHASE), 0);
      chk("islot PRD_EN", 32'(PRD_EN), 0);
      tick(3);
      chk("islot FRAME", 32'(FRAME), 1);
      chk("islot WB_EN", 32'(WB_EN), 0);
`endif
      RUN = 0;
      tick(FL + 2);
      chk("end BUSY", 32'(BUSY), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
